ysyx_22050612_ifu: RTL and testbench

Instruction fetch unit directly upstream of the execute stage in the ysyx_22050612 core. It holds the architectural PC, issues one fetch at a time to instruction memory over a valid/ready request plus valid-only response, buffers the returned 32-bit instruction, and presents it with its PC to decode/execute over valid/ready. It then waits for the execute stage to return dnpc before fetching again. No speculation.

---
 rtl/ysyx_22050612_ifu_pkg.sv | 17 +
 rtl/ysyx_22050612_pc_reg.sv | 26 ++
 rtl/ysyx_22050612_ifu.sv | 111 +++++++++++
 tb/tb_ysyx_22050612_ifu.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050612_ifu_pkg.sv
// Shared types and constants for the ysyx_22050612 instruction fetch unit.
// State encoding, instruction width and default reset PC.
package ysyx_22050612_ifu_pkg;

    localparam int          INST_W       = 32;
    localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT     = 3'd2,
        S_HOLD     = 3'd3,
        S_WAIT_NPC = 3'd4,
        S_HALT     = 3'd5
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22050612_pc_reg.sv
// Program counter register for the ysyx_22050612 IFU.
// Async active-low reset to RESET_PC, loads d_i when ld_i is high.
module ysyx_22050612_pc_reg #(
    parameter int             XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_i,
    input  logic [XLEN-1:0] d_i,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (ld_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// ysyx_22050612 instruction fetch unit: one fetch in flight, no speculation.
// Optional IFU_PERF_EN adds a 64-bit handshake counter on fetch_cnt.
module ysyx_22050612_ifu
    import ysyx_22050612_ifu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   pc,
    input  logic              npc_valid,
    input  logic [XLEN-1:0]   dnpc,
    output logic              misalign,
    output logic [63:0]       fetch_cnt
);

    ifu_state_e        state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              misalign_q, misalign_d;
    logic [XLEN-1:0]   pc_q;
    logic              npc_take;
    logic              dnpc_bad;

    assign npc_take = npc_valid &&
                      ((state_q == S_HOLD && inst_ready) ||
                       state_q == S_WAIT_NPC);
    assign dnpc_bad = |dnpc[1:0];

    ysyx_22050612_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (npc_take),
        .d_i   (dnpc),
        .q_o   (pc_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            inst_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (imem_req_ready) state_d = S_WAIT;
            S_WAIT:     if (imem_resp_valid) state_d = S_HOLD;
            S_HOLD:     if (inst_ready) state_d = S_WAIT_NPC;
            S_WAIT_NPC: state_d = S_WAIT_NPC;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_IDLE;
        endcase
        // a returned dnpc overrides both HOLD and WAIT_NPC
        if (npc_take) begin
            state_d = dnpc_bad ? S_HALT : S_FETCH;
        end
    end

    always_comb begin
        inst_d     = inst_q;
        misalign_d = misalign_q | (npc_take & dnpc_bad);
        if (state_q == S_WAIT && imem_resp_valid) begin
            inst_d = imem_rdata;
        end
    end

    always_comb begin
        imem_req_valid = (state_q == S_FETCH);
        inst_valid     = (state_q == S_HOLD);
        imem_addr      = pc_q;
        pc             = pc_q;
        inst           = inst_q;
        misalign       = misalign_q;
    end

`ifdef IFU_PERF_EN
    logic [63:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inst_valid && inst_ready) begin
            cnt_q <= cnt_q + 64'd1;
        end
    end

    assign fetch_cnt = cnt_q;
`else
    assign fetch_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Scoreboard bench for ysyx_22050612_ifu.
// Responses push {pc, inst}; downstream handshakes pop and compare.
module tb_ysyx_22050612_ifu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        npc_valid = 1'b0;
    logic [63:0] dnpc = '0;
    logic        misalign;
    logic [63:0] fetch_cnt;

    int    n_cmp = 0;
    int    n_bad = 0;
    sb_t   sb_q[$];
    longint unsigned hs_cnt = 0;

    ysyx_22050612_ifu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc              (pc),
        .npc_valid       (npc_valid),
        .dnpc            (dnpc),
        .misalign        (misalign),
        .fetch_cnt       (fetch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] want_cnt();
`ifdef IFU_PERF_EN
        return hs_cnt;
`else
        return 64'd0;
`endif
    endfunction

    // memory side: one-cycle response pulse, expectation pushed as it is driven
    task automatic respond(input logic [63:0] exp_pc, input logic [31:0] d);
        imem_resp_valid = 1'b1;
        imem_rdata      = d;
        sb_q.push_back('{pc: exp_pc, inst: d});
        tick();
        imem_resp_valid = 1'b0;
    endtask

    task automatic accept();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (imem_req_valid !== 1'b0)
            begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++;
        if (inst_valid !== 1'b0)
            begin n_bad++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
        n_cmp++;
        if (pc !== RST_PC)
            begin n_bad++; $display("FAIL rst_pc: got %h want %h", pc, RST_PC); end
        n_cmp++;
        if (inst !== 32'h0 || misalign !== 1'b0)
            begin n_bad++; $display("FAIL rst_inst_mis: got %h/%b want 0/0", inst, misalign); end
        n_cmp++;
        if (fetch_cnt !== 64'd0)
            begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", fetch_cnt); end
    endtask

    task automatic test_first_fetch();
        sb_t e;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC)
            begin n_bad++; $display("FAIL first_req: got %b/%h want 1/%h", imem_req_valid, imem_addr, RST_PC); end
        accept();
        n_cmp++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
            begin n_bad++; $display("FAIL first_wait: got req %b iv %b want 0 0", imem_req_valid, inst_valid); end
        respond(RST_PC, 32'h0000_0513);
        n_cmp++;
        if (inst_valid !== 1'b1)
            begin n_bad++; $display("FAIL first_iv: got %b want 1", inst_valid); end
        e = sb_q.pop_front();
        n_cmp++;
        if (inst !== e.inst || pc !== e.pc)
            begin n_bad++; $display("FAIL first_data: got %h@%h want %h@%h", inst, pc, e.inst, e.pc); end
        inst_ready = 1'b1;
        npc_valid  = 1'b1;
        dnpc       = 64'h8000_0004;
        tick();
        hs_cnt++;
        inst_ready = 1'b0;
        npc_valid  = 1'b0;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0004)
            begin n_bad++; $display("FAIL bypass_req: got %b/%h want 1/80000004", imem_req_valid, imem_addr); end
    endtask

    task automatic test_req_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0004 || inst_valid !== 1'b0)
                begin n_bad++; $display("FAIL stall_req%0d: got %b/%h iv %b", i, imem_req_valid, imem_addr, inst_valid); end
        end
        accept();
        tick();
        n_cmp++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
            begin n_bad++; $display("FAIL stall_wait: got req %b iv %b want 0 0", imem_req_valid, inst_valid); end
        respond(64'h8000_0004, 32'h0010_0093);
    endtask

    task automatic test_hold_stall();
        sb_t e;
        e = sb_q[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (inst_valid !== 1'b1 || inst !== e.inst || pc !== e.pc)
                begin n_bad++; $display("FAIL hold%0d: got %b %h@%h want 1 %h@%h", i, inst_valid, inst, pc, e.inst, e.pc); end
        end
        e = sb_q.pop_front();
        inst_ready = 1'b1;
        npc_valid  = 1'b1;
        dnpc       = 64'h8000_0008;
        tick();
        hs_cnt++;
        inst_ready = 1'b0;
        npc_valid  = 1'b0;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0008)
            begin n_bad++; $display("FAIL hold_next: got %b/%h want 1/80000008", imem_req_valid, imem_addr); end
    endtask

    task automatic test_wait_npc();
        sb_t e;
        accept();
        respond(64'h8000_0008, 32'h0020_0113);
        e = sb_q.pop_front();
        n_cmp++;
        if (inst_valid !== 1'b1 || inst !== e.inst || pc !== e.pc)
            begin n_bad++; $display("FAIL wnpc_data: got %b %h@%h want 1 %h@%h", inst_valid, inst, pc, e.inst, e.pc); end
        inst_ready = 1'b1;
        tick();
        hs_cnt++;
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_resp_valid = (i == 1);
            tick();
            n_cmp++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
                begin n_bad++; $display("FAIL wnpc_idle%0d: got req %b iv %b want 0 0", i, imem_req_valid, inst_valid); end
        end
        imem_resp_valid = 1'b0;
        n_cmp++;
        if (fetch_cnt !== want_cnt())
            begin n_bad++; $display("FAIL cnt_three: got %0d want %0d", fetch_cnt, want_cnt()); end
        npc_valid = 1'b1;
        dnpc      = 64'h8000_0100;
        tick();
        npc_valid = 1'b0;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0100)
            begin n_bad++; $display("FAIL wnpc_req: got %b/%h want 1/80000100", imem_req_valid, imem_addr); end
    endtask

    task automatic test_misalign();
        sb_t e;
        accept();
        respond(64'h8000_0100, 32'h0030_0193);
        e = sb_q.pop_front();
        n_cmp++;
        if (inst !== e.inst || pc !== e.pc)
            begin n_bad++; $display("FAIL mis_data: got %h@%h want %h@%h", inst, pc, e.inst, e.pc); end
        inst_ready = 1'b1;
        npc_valid  = 1'b1;
        dnpc       = 64'h8000_0102;
        tick();
        hs_cnt++;
        inst_ready = 1'b0;
        npc_valid  = 1'b0;
        n_cmp++;
        if (misalign !== 1'b1 || pc !== 64'h8000_0102)
            begin n_bad++; $display("FAIL mis_flag: got %b pc %h want 1 80000102", misalign, pc); end
        imem_req_ready = 1'b1;
        npc_valid      = 1'b1;
        dnpc           = 64'h8000_0200;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== 64'h8000_0102)
                begin n_bad++; $display("FAIL halt%0d: got req %b iv %b pc %h", i, imem_req_valid, inst_valid, pc); end
        end
        imem_req_ready = 1'b0;
        npc_valid      = 1'b0;
        n_cmp++;
        if (fetch_cnt !== want_cnt())
            begin n_bad++; $display("FAIL cnt_four: got %0d want %0d", fetch_cnt, want_cnt()); end
        rst_n = 1'b0;
        hs_cnt = 0;
        #1;
        n_cmp++;
        if (misalign !== 1'b0 || pc !== RST_PC || fetch_cnt !== want_cnt())
            begin n_bad++; $display("FAIL mis_rst: got %b %h cnt %0d want 0 %h 0", misalign, pc, fetch_cnt, RST_PC); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC)
            begin n_bad++; $display("FAIL mis_restart: got %b/%h want 1/%h", imem_req_valid, imem_addr, RST_PC); end
    endtask

    task automatic test_reset_in_wait();
        accept();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
            begin n_bad++; $display("FAIL rw_rst: got req %b iv %b want 0 0", imem_req_valid, inst_valid); end
        tick();
        rst_n           = 1'b1;
        imem_resp_valid = 1'b1;
        imem_rdata      = 32'hDEAD_BEEF;
        tick();
        n_cmp++;
        if (imem_req_valid !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'h0)
            begin n_bad++; $display("FAIL rw_stale: got req %b iv %b inst %h want 1 0 0", imem_req_valid, inst_valid, inst); end
        tick();
        imem_resp_valid = 1'b0;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || inst !== 32'h0 || imem_addr !== RST_PC)
            begin n_bad++; $display("FAIL rw_fetch: got req %b inst %h addr %h", imem_req_valid, inst, imem_addr); end
    endtask

    task automatic test_back_to_back();
        sb_t         e;
        logic [63:0] a;
        logic [31:0] d;
        a = RST_PC;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (imem_req_valid !== 1'b1 || imem_addr !== a)
                begin n_bad++; $display("FAIL b2b_req%0d: got %b/%h want 1/%h", i, imem_req_valid, imem_addr, a); end
            d = $urandom;
            accept();
            respond(a, d);
            e = sb_q.pop_front();
            n_cmp++;
            if (inst_valid !== 1'b1 || inst !== e.inst || pc !== e.pc)
                begin n_bad++; $display("FAIL b2b_data%0d: got %b %h@%h want 1 %h@%h", i, inst_valid, inst, pc, e.inst, e.pc); end
            a          = a + 64'd4;
            inst_ready = 1'b1;
            npc_valid  = 1'b1;
            dnpc       = a;
            tick();
            hs_cnt++;
            inst_ready = 1'b0;
            npc_valid  = 1'b0;
        end
        n_cmp++;
        if (fetch_cnt !== want_cnt())
            begin n_bad++; $display("FAIL b2b_cnt: got %0d want %0d", fetch_cnt, want_cnt()); end
        n_cmp++;
        if (sb_q.size() != 0)
            begin n_bad++; $display("FAIL sb_empty: got %0d left want 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_req_stall();
        test_hold_stall();
        test_wait_npc();
        test_misalign();
        test_reset_in_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
